// File: rtl/updown_mode_counter_pkg.sv
// Shared encodings for the up/down mode counter and its next-value helper.
package updown_mode_counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_RELOAD  = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

endpackage

// File: rtl/updown_next_value.sv
// Combinational step logic: given the current count, returns the value after
// one enabled step and whether the count is sitting at its terminal value.
module updown_next_value
    import updown_mode_counter_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] q_i,
    input  logic [N-1:0] r_i,
    input  logic [N-1:0] limit_i,
    input  logic         up_i,
    input  logic [1:0]   mode_i,
    output logic [N-1:0] next_q_o,
    output logic         at_term_o
);

    logic [N-1:0] reloadVal;

    // Up uses >= so a limit lowered below the count still counts as terminal.
    always_comb begin
        reloadVal = (r_i > limit_i) ? limit_i : r_i;
        at_term_o = up_i ? (q_i >= limit_i) : (q_i == '0);
        next_q_o  = up_i ? (q_i + 1'b1) : (q_i - 1'b1);

        if (at_term_o) begin
            case (mode_e'(mode_i))
                MODE_WRAP:    next_q_o = up_i ? '0 : limit_i;
                MODE_SAT:     next_q_o = up_i ? limit_i : q_i;
                MODE_RELOAD:  next_q_o = reloadVal;
                MODE_ONESHOT: next_q_o = up_i ? limit_i : q_i;
            endcase
        end
    end

endmodule

// File: rtl/updown_mode_counter.sv
// N-bit up/down counter with wrap, saturate, auto-reload and one-shot terminal
// behaviour; holds the count, terminal-count pulse and run/halt state.
module updown_mode_counter
    import updown_mode_counter_pkg::*;
#(
    parameter int          N           = 8,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] r_i,
    input  logic [N-1:0] limit_i,
    input  logic         l_i,
    input  logic         e_i,
    input  logic         up_i,
    input  logic [1:0]   mode_i,
    output logic [N-1:0] q_o,
    output logic         tc_o,
    output logic         zero_o,
    output logic         done_o
);

    logic [N-1:0] q_q, q_d;
    logic         tc_q, tc_d;
    state_e       state_q, state_d;

    logic [N-1:0] stepVal;
    logic         atTerm;
    logic [N-1:0] loadVal;

    updown_next_value #(.N(N)) u_next (
        .q_i       (q_q),
        .r_i       (r_i),
        .limit_i   (limit_i),
        .up_i      (up_i),
        .mode_i    (mode_i),
        .next_q_o  (stepVal),
        .at_term_o (atTerm)
    );

    assign loadVal = (r_i > limit_i) ? limit_i : r_i;

    // Load beats count; a halted one-shot ignores everything but load.
    always_comb begin
        q_d     = q_q;
        tc_d    = 1'b0;
        state_d = state_q;

        if (l_i) begin
            q_d     = loadVal;
            state_d = ST_RUN;
        end else if (state_q == ST_RUN && e_i) begin
            q_d  = stepVal;
            tc_d = atTerm;
            if (atTerm && mode_e'(mode_i) == MODE_ONESHOT) begin
                state_d = ST_HALT;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q     <= N'(RESET_VALUE);
            tc_q    <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            q_q     <= q_d;
            tc_q    <= tc_d;
            state_q <= state_d;
        end
    end

    assign q_o    = q_q;
    assign tc_o   = tc_q;
    assign zero_o = (q_q == '0);
    assign done_o = (state_q == ST_HALT);

endmodule

// File: tb/tb_updown_mode_counter.sv
// Self-checking bench: directed vector table, hand-written reset sequences and
// randomized traffic against a behavioural model of the counter.
module tb_updown_mode_counter;

    logic       clk;
    logic       rst;
    logic [7:0] r, limit;
    logic       l, e, up;
    logic [1:0] mode;
    logic [7:0] q, q5;
    logic       tc, zero, done, tc5, zero5, done5;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int mq;
    bit mtc;
    bit mhalt;

    typedef struct {
        string      name;
        logic       l, e, up;
        logic [1:0] mode;
        logic [7:0] r, limit;
        int         expQ;
        bit         expTc, expDone;
    } vec_t;

    vec_t vecs[$];

    updown_mode_counter #(.N(8), .RESET_VALUE(0)) dut (
        .clk_i(clk), .rst_i(rst), .r_i(r), .limit_i(limit), .l_i(l), .e_i(e),
        .up_i(up), .mode_i(mode), .q_o(q), .tc_o(tc), .zero_o(zero), .done_o(done)
    );

    updown_mode_counter #(.N(8), .RESET_VALUE(5)) dut5 (
        .clk_i(clk), .rst_i(rst), .r_i(r), .limit_i(limit), .l_i(l), .e_i(e),
        .up_i(up), .mode_i(mode), .q_o(q5), .tc_o(tc5), .zero_o(zero5), .done_o(done5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name, input int expQ, input bit expTc, input bit expDone);
        compare({name, " q"}, int'(q), expQ);
        compare({name, " tc"}, int'(tc), int'(expTc));
        compare({name, " done"}, int'(done), int'(expDone));
        compare({name, " zero"}, int'(zero), (expQ == 0) ? 1 : 0);
    endtask

    // Model of one rising edge, written straight from the counter's rules.
    task automatic modelStep(input bit il, input bit ie, input bit iup, input int imode,
                             input int ir, input int ilimit);
        bit atTerm;
        if (il) begin
            mq    = (ir < ilimit) ? ir : ilimit;
            mtc   = 0;
            mhalt = 0;
        end else if (mhalt || !ie) begin
            mtc = 0;
        end else begin
            atTerm = iup ? (mq >= ilimit) : (mq == 0);
            mtc    = atTerm;
            if (!atTerm) begin
                mq = iup ? mq + 1 : mq - 1;
            end else if (imode == 0) begin
                mq = iup ? 0 : ilimit;
            end else if (imode == 2) begin
                mq = (ir < ilimit) ? ir : ilimit;
            end else begin
                if (iup) mq = ilimit;
                if (imode == 3) mhalt = 1;
            end
        end
    endtask

    task automatic applyStimulus(input bit il, input bit ie, input bit iup, input int imode,
                                 input int ir, input int ilimit);
        l = il; e = ie; up = iup; mode = imode[1:0]; r = ir[7:0]; limit = ilimit[7:0];
        @(posedge clk);
        #1;
        modelStep(il, ie, iup, imode, ir, ilimit);
    endtask

    task automatic addVec(input string name, input bit il, input bit ie, input bit iup,
                          input int imode, input int ir, input int ilimit,
                          input int expQ, input bit expTc, input bit expDone);
        vec_t v;
        v.name = name; v.l = il; v.e = ie; v.up = iup; v.mode = imode[1:0];
        v.r = ir[7:0]; v.limit = ilimit[7:0];
        v.expQ = expQ; v.expTc = expTc; v.expDone = expDone;
        vecs.push_back(v);
    endtask

    task automatic asyncReset(input string name);
        #2 rst = 1'b1;
        #1;
        mq = 0; mtc = 0; mhalt = 0;
        checkOutput(name, 0, 0, 0);
        compare({name, " q RESET_VALUE=5"}, int'(q5), 5);
        #1 rst = 1'b0;
    endtask

    initial begin
        // name, l, e, up, mode, r, limit, expQ, expTc, expDone
        addVec("wrapdn load", 1, 0, 0, 0, 2, 9, 2, 0, 0);
        addVec("wrapdn 1",    0, 1, 0, 0, 2, 9, 1, 0, 0);
        addVec("wrapdn 0",    0, 1, 0, 0, 2, 9, 0, 0, 0);
        addVec("wrapdn 9",    0, 1, 0, 0, 2, 9, 9, 1, 0);
        addVec("wrapdn 8",    0, 1, 0, 0, 2, 9, 8, 0, 0);
        addVec("sat load",    1, 0, 1, 1, 4, 5, 4, 0, 0);
        addVec("sat 5",       0, 1, 1, 1, 4, 5, 5, 0, 0);
        addVec("sat hold1",   0, 1, 1, 1, 4, 5, 5, 1, 0);
        addVec("sat hold2",   0, 1, 1, 1, 4, 5, 5, 1, 0);
        addVec("sat e0",      0, 0, 1, 1, 4, 5, 5, 0, 0);
        addVec("rld load",    1, 0, 0, 2, 3, 255, 3, 0, 0);
        addVec("rld 2",       0, 1, 0, 2, 3, 255, 2, 0, 0);
        addVec("rld 1",       0, 1, 0, 2, 3, 255, 1, 0, 0);
        addVec("rld 0",       0, 1, 0, 2, 3, 255, 0, 0, 0);
        addVec("rld 3",       0, 1, 0, 2, 3, 255, 3, 1, 0);
        addVec("rld 2b",      0, 1, 0, 2, 3, 255, 2, 0, 0);
        addVec("rldclamp ld", 1, 0, 0, 2, 200, 2, 2, 0, 0);
        addVec("rldclamp 1",  0, 1, 0, 2, 200, 2, 1, 0, 0);
        addVec("rldclamp 0",  0, 1, 0, 2, 200, 2, 0, 0, 0);
        addVec("rldclamp 2",  0, 1, 0, 2, 200, 2, 2, 1, 0);
        addVec("rld100 ld",   1, 0, 1, 2, 200, 100, 100, 0, 0);
        addVec("rld100 up",   0, 1, 1, 2, 200, 100, 100, 1, 0);
        addVec("os load",     1, 0, 1, 3, 1, 4, 1, 0, 0);
        addVec("os 2",        0, 1, 1, 3, 1, 4, 2, 0, 0);
        addVec("os 3",        0, 1, 1, 3, 1, 4, 3, 0, 0);
        addVec("os 4",        0, 1, 1, 3, 1, 4, 4, 0, 0);
        addVec("os halt",     0, 1, 1, 3, 1, 4, 4, 1, 1);
        addVec("os held",     0, 1, 1, 3, 1, 4, 4, 0, 1);
        addVec("os toggle",   0, 1, 0, 0, 1, 4, 4, 0, 1);
        addVec("os e0",       0, 0, 1, 2, 1, 4, 4, 0, 1);
        addVec("os reload0",  1, 0, 1, 3, 0, 4, 0, 0, 0);
        addVec("os resume",   0, 1, 1, 3, 0, 4, 1, 0, 0);
        addVec("l+e",         1, 1, 1, 0, 7, 255, 7, 0, 0);
        addVec("lim ld80",    1, 0, 1, 0, 80, 255, 80, 0, 0);
        addVec("lim lower",   0, 1, 1, 0, 80, 50, 0, 1, 0);
        addVec("lim0 load",   1, 0, 1, 0, 9, 0, 0, 0, 0);
        addVec("lim0 up",     0, 1, 1, 0, 9, 0, 0, 1, 0);
        addVec("lim0 dn sat", 0, 1, 0, 1, 9, 0, 0, 1, 0);

        rst = 1'b1; l = 0; e = 0; up = 0; mode = 0; r = 0; limit = 8'd255;
        mq = 0; mtc = 0; mhalt = 0;
        #3;
        checkOutput("reset", 0, 0, 0);
        compare("reset q RESET_VALUE=5", int'(q5), 5);
        #4 rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].l, vecs[i].e, vecs[i].up, int'(vecs[i].mode),
                          int'(vecs[i].r), int'(vecs[i].limit));
            checkOutput(vecs[i].name, vecs[i].expQ, vecs[i].expTc, vecs[i].expDone);
        end

        // Reset mid-count aborts the count without a terminal pulse.
        applyStimulus(1, 0, 1, 0, 30, 255);
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, 1, 0, 30, 255);
        checkOutput("pre-reset", 37, 0, 0);
        asyncReset("async reset");

        // Reset also releases a halted one-shot.
        applyStimulus(1, 0, 1, 3, 3, 4);
        applyStimulus(0, 1, 1, 3, 3, 4);
        applyStimulus(0, 1, 1, 3, 3, 4);
        checkOutput("os pre-reset", 4, 1, 1);
        asyncReset("halt reset");

        for (int i = 0; i < 600; i++) begin
            int rl, rlim;
            rlim = int'(limit);
            if ($urandom_range(0, 19) == 0)
                rlim = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 20));
            rl = ($urandom_range(0, 11) == 0) ? 1 : 0;
            applyStimulus(rl[0], $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 30)), rlim);
            checkOutput("rand", mq, mtc, mhalt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_mode_counter.md
Name: updown_mode_counter

Overview:
- Parametrised N-bit up/down counter; successor to the team's plain loadable down-counter.
- Adds a direction input, a programmable terminal limit and four terminal-count modes: wrap, saturate, auto-reload and one-shot.
- Drives terminal-count, zero and done flags.
- Sits as a general timer/sequencer primitive driven by control FSMs in the same clock domain.

Parameters:
- N, 8, counter width in bits.
- RESET_VALUE, 0, value of Q after reset; must fit in N bits.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- R  input  N  parallel load value; also the reload value in auto-reload mode.
- Limit  input  N  upper terminal value; count range is 0..Limit.
- L  input  1  synchronous load.
- E  input  1  count enable.
- Up  input  1  direction: 1 = increment, 0 = decrement.
- Mode  input  2  terminal behaviour: 00 wrap, 01 saturate, 10 auto-reload, 11 one-shot.
- Q  output  N  registered count.
- TC  output  1  registered terminal-count pulse.
- Zero  output  1  combinational, equals (Q == 0).
- Done  output  1  registered; high while halted in one-shot mode.

Behaviour:
- Reset (asynchronous, high):
  - Q = RESET_VALUE, TC = 0, Done = 0, state = RUN.
  - Takes effect immediately, independent of Clock.
  - Reset asserted mid-count aborts the count; no TC is generated.
- Priority per rising edge: Reset > L > E. When L=1 and E=1 together, the load wins and no count step occurs that cycle.
- Load: Q <= min(R, Limit). Load clears Done and returns the state to RUN. TC = 0 in the load cycle.
- Terminal condition:
  - Up=1: Q >= Limit. The >= also covers Limit lowered below Q mid-run.
  - Up=0: Q == 0.
- Enabled step (E=1, L=0, state RUN):
  - Not at terminal: Q <= Q+1 (Up=1) or Q-1 (Up=0).
  - At terminal, wrap: Up=1 -> 0; Up=0 -> Limit.
  - At terminal, saturate: Q holds (up: Q <= Limit, clamping a Q above Limit).
  - At terminal, auto-reload: Q <= min(R, Limit), both directions.
  - At terminal, one-shot: Q holds (up clamps to Limit); state -> HALT.
- TC: asserted for the cycle following every enabled step taken from a terminal value, all modes; otherwise 0.
  - Saturate with E held at terminal: TC stays high every cycle.
  - One-shot: exactly one TC cycle, coincident with Done rising.
- State machine, two states:
  - RUN -> HALT on an enabled one-shot step at terminal.
  - HALT -> RUN only on L or Reset.
  - In HALT: E, Up and Mode are ignored; Q holds; Done = 1.
- Mode, Up and Limit are sampled every cycle, with no restriction on changing them mid-run. Leaving mode 11 while in HALT does not release the halt.
- E=0: Q holds, TC = 0.
- Width rules: all arithmetic is N bits unsigned; no carry out. Limit = 0 is legal: Q is stuck at 0 and every enabled step is a terminal step.

Decomposition:
- Shared package:
  - Mode encodings: MODE_WRAP = 2'b00, MODE_SAT = 2'b01, MODE_RELOAD = 2'b10, MODE_ONESHOT = 2'b11.
  - State encodings: ST_RUN, ST_HALT.
- One combinational sub-module, updown_next_value: inputs Q, R, Limit, Up, Mode; outputs next Q and an at-terminal flag.
- The top level holds the Q, TC and state registers, the priority logic and the Done decode.

Test Plan:
- Async reset: count to Q=37, pulse Reset between clock edges -> Q=0, TC=0, Done=0, Zero=1 before the next edge; with RESET_VALUE=5 -> Q=5.
- Wrap down: Limit=9, load R=2, Up=0, Mode=00, E=1 -> Q 2,1,0,9,8; TC=1 only in the cycle Q=9.
- Saturate up: Limit=5, load R=4, Mode=01 -> Q 4,5,5,5; TC=1 from the cycle after the first step attempted at 5; drop E -> TC=0, Q=5.
- Auto-reload down: R=3, Mode=10, Limit=255 -> Q 3,2,1,0,3,2; TC=1 in the cycle Q returns to 3. Same test with R=200, Limit=100 -> reload value 100.
- One-shot up: Limit=4, load R=1, Mode=11 -> Q 1,2,3,4,4; Done=1 and a single TC pulse. Toggle Up/E/Mode -> Q stays 4. Then L=1, R=0 -> Q=0, Done=0, counting resumes.
- Collisions:
  - L=1 and E=1 with R=7 -> Q=7, no step.
  - Load R=200 with Limit=100 -> Q=100.
  - Lower Limit to 50 while Q=80 counting up in wrap -> next Q=0, TC=1.
